// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Front-end command sequencer for the 8-bit ALU. Collects 3-byte frames
//   (opcode, operand A, operand B) from a host byte stream. It drives the ALU
//   inputs and holds them stable for ALU_LAT+1 cycles, then captures the ALU
//   result and offers it downstream on a valid/ready handshake.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_data/valid/ready host byte stream (accept on in_valid && in_ready)
//   alu_data_in1/2      operands A/B driven to the ALU
//   alu_operation       operation code driven to the ALU
//   alu_data_out        ALU result, sampled at the end of EXEC
//   res_data/res_op     captured result and the operation that produced it
//   res_valid/res_ready downstream result handshake
//   err                 one-cycle pulse on bad sync nibble or frame timeout
module alu_cmd_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OP_W    = 4,
    parameter logic [3:0]  SYNC    = 4'hA,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_data_in1,
    output logic [DATA_W-1:0] alu_data_in2,
    output logic [OP_W-1:0]   alu_operation,
    input  logic [DATA_W-1:0] alu_data_out,
    output logic [DATA_W-1:0] res_data,
    output logic [OP_W-1:0]   res_op,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              err
);

    localparam logic [2:0] ST_GET_OP = 3'd0;
    localparam logic [2:0] ST_GET_A  = 3'd1;
    localparam logic [2:0] ST_GET_B  = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam int unsigned    TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] IDLE_MAX = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [2:0]     EXEC_LAST = 3'(ALU_LAT);

    logic [2:0]        r_state,     w_state_nxt;
    logic [OP_W-1:0]   r_op_sh,     w_op_sh_nxt;
    logic [DATA_W-1:0] r_a_sh,      w_a_sh_nxt;
    logic [DATA_W-1:0] r_alu_a,     w_alu_a_nxt;
    logic [DATA_W-1:0] r_alu_b,     w_alu_b_nxt;
    logic [OP_W-1:0]   r_alu_op,    w_alu_op_nxt;
    logic [DATA_W-1:0] r_res_data,  w_res_data_nxt;
    logic [OP_W-1:0]   r_res_op,    w_res_op_nxt;
    logic [2:0]        r_exec_cnt,  w_exec_cnt_nxt;
    logic [TO_W-1:0]   r_idle_cnt,  w_idle_cnt_nxt;
    logic              r_err,       w_err_nxt;

    logic w_in_ready;
    logic w_accept;
    logic w_in_frame;
    logic w_timeout;
    logic w_sync_ok;

    assign w_in_ready = (r_state == ST_GET_OP) || (r_state == ST_GET_A) ||
                        (r_state == ST_GET_B);
    assign w_accept   = in_valid && w_in_ready;
    assign w_in_frame = (r_state == ST_GET_A) || (r_state == ST_GET_B);
    assign w_sync_ok  = (in_data[DATA_W-1 -: 4] == SYNC);

    // An accept in the same cycle takes priority over the abort.
    assign w_timeout  = (TIMEOUT != 0) && w_in_frame && !w_accept &&
                        (r_idle_cnt == IDLE_MAX);

    always_comb begin
        w_state_nxt    = r_state;
        w_op_sh_nxt    = r_op_sh;
        w_a_sh_nxt     = r_a_sh;
        w_alu_a_nxt    = r_alu_a;
        w_alu_b_nxt    = r_alu_b;
        w_alu_op_nxt   = r_alu_op;
        w_res_data_nxt = r_res_data;
        w_res_op_nxt   = r_res_op;
        w_exec_cnt_nxt = r_exec_cnt;
        w_err_nxt      = 1'b0;

        // Idle counter only runs while a frame is partially received.
        if (w_accept || !w_in_frame || w_timeout) begin
            w_idle_cnt_nxt = '0;
        end else begin
            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end

        case (r_state)
            ST_GET_OP: begin
                if (w_accept) begin
                    if (w_sync_ok) begin
                        w_op_sh_nxt = in_data[OP_W-1:0];
                        w_state_nxt = ST_GET_A;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_GET_A: begin
                if (w_accept) begin
                    w_a_sh_nxt  = in_data;
                    w_state_nxt = ST_GET_B;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_GET_OP;
                end
            end
            ST_GET_B: begin
                if (w_accept) begin
                    w_alu_a_nxt    = r_a_sh;
                    w_alu_b_nxt    = in_data;
                    w_alu_op_nxt   = r_op_sh;
                    w_exec_cnt_nxt = 3'd0;
                    w_state_nxt    = ST_EXEC;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_GET_OP;
                end
            end
            ST_EXEC: begin
                if (r_exec_cnt == EXEC_LAST) begin
                    w_res_data_nxt = alu_data_out;
                    w_res_op_nxt   = r_alu_op;
                    w_state_nxt    = ST_HOLD;
                end else begin
                    w_exec_cnt_nxt = r_exec_cnt + 3'd1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    w_state_nxt = ST_GET_OP;
                end
            end
            default: begin
                w_state_nxt = ST_GET_OP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_GET_OP;
            r_op_sh    <= '0;
            r_a_sh     <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_res_data <= '0;
            r_res_op   <= '0;
            r_exec_cnt <= '0;
            r_idle_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op_sh    <= w_op_sh_nxt;
            r_a_sh     <= w_a_sh_nxt;
            r_alu_a    <= w_alu_a_nxt;
            r_alu_b    <= w_alu_b_nxt;
            r_alu_op   <= w_alu_op_nxt;
            r_res_data <= w_res_data_nxt;
            r_res_op   <= w_res_op_nxt;
            r_exec_cnt <= w_exec_cnt_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign in_ready      = w_in_ready;
    assign alu_data_in1  = r_alu_a;
    assign alu_data_in2  = r_alu_b;
    assign alu_operation = r_alu_op;
    assign res_data      = r_res_data;
    assign res_op        = r_res_op;
    assign res_valid     = (r_state == ST_HOLD);
    assign err           = r_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Self-checking bench for alu_cmd_sequencer. Three instances with ALU_LAT of
//   1, 0 and 3 share clock and reset. Each has a behavioural ALU that produces
//   its result ALU_LAT cycles after its inputs. Expected results come from
//   frame contents and the frame timing rules.
module tb_alu_cmd_sequencer;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic [NDUT-1:0][7:0]     in_data;
    logic [NDUT-1:0]          in_valid;
    logic [NDUT-1:0]          in_ready;
    logic [NDUT-1:0][7:0]     alu_in1;
    logic [NDUT-1:0][7:0]     alu_in2;
    logic [NDUT-1:0][3:0]     alu_op;
    logic [NDUT-1:0][7:0]     alu_out;
    logic [NDUT-1:0][7:0]     res_data;
    logic [NDUT-1:0][3:0]     res_op;
    logic [NDUT-1:0]          res_valid;
    logic [NDUT-1:0]          res_ready;
    logic [NDUT-1:0]          err;

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return {a[6:0], 1'b0};
            4'd7:    return {1'b0, a[7:1]};
            4'd8:    return a + 8'd1;
            4'd9:    return a - 8'd1;
            4'd10:   return b;
            4'd11:   return a;
            4'd12:   return ~(a & b);
            4'd13:   return ~(a | b);
            4'd14:   return {a[6:0], a[7]};
            default: return {a[0], a[7:1]};
        endcase
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [7:0] hist [8];

        alu_cmd_sequencer #(.ALU_LAT(LAT)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_data      (in_data[g]),
            .in_valid     (in_valid[g]),
            .in_ready     (in_ready[g]),
            .alu_data_in1 (alu_in1[g]),
            .alu_data_in2 (alu_in2[g]),
            .alu_operation(alu_op[g]),
            .alu_data_out (alu_out[g]),
            .res_data     (res_data[g]),
            .res_op       (res_op[g]),
            .res_valid    (res_valid[g]),
            .res_ready    (res_ready[g]),
            .err          (err[g])
        );

        // ALU with LAT cycles of latency: result of the inputs seen LAT cycles ago.
        always @(posedge clk) begin
            hist[0] <= alu_fn(alu_op[g], alu_in1[g], alu_in2[g]);
            for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
        end
        if (LAT == 0) begin : g_comb
            assign alu_out[g] = alu_fn(alu_op[g], alu_in1[g], alu_in2[g]);
        end else begin : g_dly
            assign alu_out[g] = hist[LAT-1];
        end
    end

    // Present one byte and return #1 after the edge that accepted it.
    task automatic send_byte(input int d, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data[d]  = b;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            total++; bad++;
            $display("FAIL send_byte dut%0d: in_ready got 0 want 1 after 50 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    // Count edges until res_valid is seen; returns the count.
    task automatic wait_res(input int d, output int cyc);
        cyc = 0;
        while (!res_valid[d] && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!res_valid[d]) begin
            total++; bad++;
            $display("FAIL wait_res dut%0d: res_valid got 0 want 1 within 40 cycles", d);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            total++;
            if ({in_ready[d], res_valid[d], err[d]} !== 3'b100) begin
                bad++;
                $display("FAIL reset_flags dut%0d: got %b want 100", d,
                         {in_ready[d], res_valid[d], err[d]});
            end
            total++;
            if ({alu_in1[d], alu_in2[d], alu_op[d], res_data[d], res_op[d]} !== 36'd0) begin
                bad++;
                $display("FAIL reset_data dut%0d: got %h want 0", d,
                         {alu_in1[d], alu_in2[d], alu_op[d], res_data[d], res_op[d]});
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            total++;
            if ({in_ready[d], res_valid[d], err[d]} !== 3'b100) begin
                bad++;
                $display("FAIL post_reset_flags dut%0d: got %b want 100", d,
                         {in_ready[d], res_valid[d], err[d]});
            end
        end
    endtask

    task automatic test_basic();
        int cyc;
        res_ready[0] = 1'b1;
        send_byte(0, 8'hA2);
        send_byte(0, 8'hCF);
        send_byte(0, 8'hB0);
        in_valid[0] = 1'b0;
        total++;
        if ({alu_in1[0], alu_in2[0], alu_op[0]} !== {8'hCF, 8'hB0, 4'd2}) begin
            bad++;
            $display("FAIL basic_alu_in: got %h want %h", {alu_in1[0], alu_in2[0], alu_op[0]},
                     {8'hCF, 8'hB0, 4'd2});
        end
        total++;
        if (in_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL basic_in_ready_exec: got %b want 0", in_ready[0]);
        end
        wait_res(0, cyc);
        total++;
        if (cyc != lat_of(0) + 1) begin
            bad++;
            $display("FAIL basic_latency: got %0d want %0d", cyc, lat_of(0) + 1);
        end
        total++;
        if (res_data[0] !== alu_fn(4'd2, 8'hCF, 8'hB0) || res_op[0] !== 4'd2) begin
            bad++;
            $display("FAIL basic_result: got %h/%h want %h/2", res_data[0], res_op[0],
                     alu_fn(4'd2, 8'hCF, 8'hB0));
        end
        @(posedge clk);
        #1;
        total++;
        if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL basic_handshake: got valid=%b ready=%b want 0/1",
                     res_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_bad_sync();
        int cyc;
        send_byte(0, 8'h52);
        in_valid[0] = 1'b0;
        total++;
        if (err[0] !== 1'b1 || in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL bad_sync_err: got err=%b ready=%b want 1/1", err[0], in_ready[0]);
        end
        @(posedge clk);
        #1;
        total++;
        if (err[0] !== 1'b0) begin
            bad++;
            $display("FAIL bad_sync_pulse_width: got err=%b want 0", err[0]);
        end
        send_byte(0, 8'hA3);
        send_byte(0, 8'h01);
        send_byte(0, 8'h02);
        in_valid[0] = 1'b0;
        wait_res(0, cyc);
        total++;
        if (res_op[0] !== 4'd3 || res_data[0] !== alu_fn(4'd3, 8'h01, 8'h02)) begin
            bad++;
            $display("FAIL bad_sync_followup: got %h/%h want %h/3", res_data[0], res_op[0],
                     alu_fn(4'd3, 8'h01, 8'h02));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [3:0] op;
        logic [7:0] a, b, exp;
        op  = 4'($urandom_range(0, 15));
        a   = 8'($urandom);
        b   = 8'($urandom);
        exp = alu_fn(op, a, b);
        res_ready[0] = 1'b0;
        send_byte(0, {4'hA, op});
        send_byte(0, a);
        send_byte(0, b);
        in_valid[0] = 1'b0;
        wait_res(0, cyc);
        // Offer a bad-sync byte while blocked: it must not be consumed.
        @(negedge clk);
        in_data[0]  = 8'h52;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (res_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || err[0] !== 1'b0) begin
                bad++;
                $display("FAIL bp_flags cyc%0d: got valid=%b ready=%b err=%b want 1/0/0", k,
                         res_valid[0], in_ready[0], err[0]);
            end
            total++;
            if ({res_data[0], res_op[0], alu_in1[0], alu_in2[0], alu_op[0]} !==
                {exp, op, a, b, op}) begin
                bad++;
                $display("FAIL bp_stable cyc%0d: got %h want %h", k,
                         {res_data[0], res_op[0], alu_in1[0], alu_in2[0], alu_op[0]},
                         {exp, op, a, b, op});
            end
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        res_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0/1", res_valid[0],
                     in_ready[0]);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        // Idle after operand A: abort exactly 16 edges after the accept.
        send_byte(0, 8'hA1);
        send_byte(0, 8'h11);
        in_valid[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (err[0] !== ((k == 16) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL timeout_err edge%0d: got %b want %b", k, err[0], (k == 16));
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (err[0] !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse_width: got %b want 0", err[0]);
        end
        // Aborted frame must be gone: a fresh opcode byte starts a new frame.
        send_byte(0, 8'hA5);
        send_byte(0, 8'h3C);
        send_byte(0, 8'h4D);
        in_valid[0] = 1'b0;
        total++;
        if ({alu_in1[0], alu_in2[0], alu_op[0]} !== {8'h3C, 8'h4D, 4'd5}) begin
            bad++;
            $display("FAIL timeout_new_frame: got %h want %h",
                     {alu_in1[0], alu_in2[0], alu_op[0]}, {8'h3C, 8'h4D, 4'd5});
        end
        wait_res(0, cyc);
        @(posedge clk);
        #1;
        // Byte arriving in the last allowed cycle wins over the abort.
        send_byte(0, 8'hA1);
        send_byte(0, 8'h22);
        in_valid[0] = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (err[0] !== 1'b0) begin
                bad++;
                $display("FAIL timeout_edge_idle edge%0d: got err=%b want 0", k, err[0]);
            end
        end
        send_byte(0, 8'h66);
        in_valid[0] = 1'b0;
        total++;
        if (err[0] !== 1'b0 || {alu_in1[0], alu_in2[0], alu_op[0]} !== {8'h22, 8'h66, 4'd1})
        begin
            bad++;
            $display("FAIL timeout_edge_accept: got err=%b alu=%h want 0/%h", err[0],
                     {alu_in1[0], alu_in2[0], alu_op[0]}, {8'h22, 8'h66, 4'd1});
        end
        wait_res(0, cyc);
        total++;
        if (res_data[0] !== alu_fn(4'd1, 8'h22, 8'h66)) begin
            bad++;
            $display("FAIL timeout_edge_result: got %h want %h", res_data[0],
                     alu_fn(4'd1, 8'h22, 8'h66));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        send_byte(0, 8'hA4);
        send_byte(0, 8'h5A);
        send_byte(0, 8'hC3);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready[0], res_valid[0], err[0]} !== 3'b100) begin
            bad++;
            $display("FAIL mid_reset_flags: got %b want 100", {in_ready[0], res_valid[0], err[0]});
        end
        total++;
        if ({alu_in1[0], alu_in2[0], alu_op[0], res_data[0], res_op[0]} !== 36'd0) begin
            bad++;
            $display("FAIL mid_reset_data: got %h want 0",
                     {alu_in1[0], alu_in2[0], alu_op[0], res_data[0], res_op[0]});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (res_valid[0] === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_reset_stale_result: got %0d valid cycles want 0", seen);
        end
        send_byte(0, 8'hA8);
        send_byte(0, 8'h44);
        send_byte(0, 8'h00);
        in_valid[0] = 1'b0;
        wait_res(0, cyc);
        total++;
        if (res_data[0] !== 8'h45 || res_op[0] !== 4'd8) begin
            bad++;
            $display("FAIL mid_reset_new_frame: got %h/%h want 45/8", res_data[0], res_op[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random(input int d);
        logic [7:0] bytes[$];
        logic [7:0] exp_d[$];
        logic [3:0] exp_op[$];
        int idx  = 0;
        int nres = 0;
        int cyc  = 0;
        int lat  = lat_of(d);
        int want;
        logic rdy, vld, rv;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] op;
            logic [7:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            bytes.push_back({4'hA, op});
            bytes.push_back(a);
            bytes.push_back(b);
            exp_d.push_back(alu_fn(op, a, b));
            exp_op.push_back(op);
        end
        res_ready[d] = 1'b1;
        while (nres < 10 && cyc < 400) begin
            @(negedge clk);
            if (idx < 30) begin
                in_valid[d] = 1'b1;
                in_data[d]  = bytes[idx];
            end else begin
                in_valid[d] = 1'b0;
            end
            rdy = in_ready[d];
            vld = in_valid[d];
            rv  = res_valid[d];
            total++;
            if (err[d] !== 1'b0) begin
                bad++;
                $display("FAIL rand_err dut%0d cyc%0d: got %b want 0", d, cyc, err[d]);
            end
            if (rv) begin
                total++;
                if (res_data[d] !== exp_d[nres] || res_op[d] !== exp_op[nres]) begin
                    bad++;
                    $display("FAIL rand_result dut%0d frame%0d: got %h/%h want %h/%h", d, nres,
                             res_data[d], res_op[d], exp_d[nres], exp_op[nres]);
                end
                want = nres * (lat + 5) + lat + 4;
                total++;
                if (cyc != want) begin
                    bad++;
                    $display("FAIL rand_timing dut%0d frame%0d: got cycle %0d want %0d", d, nres,
                             cyc, want);
                end
                nres++;
            end
            @(posedge clk);
            if (rdy && vld) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
        total++;
        if (nres != 10) begin
            bad++;
            $display("FAIL rand_count dut%0d: got %0d results want 10", d, nres);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        res_ready = '1;
        test_reset();
        test_basic();
        test_bad_sync();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random(1);
        test_random(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Front-end command sequencer for the 8-bit ALU. It accepts a byte stream of 3-byte command frames: opcode, operand A, operand B. It drives the ALU operand and operation inputs and holds them stable for the ALU latency. It then captures the ALU result and presents it downstream on a valid/ready handshake. It sits between the host byte interface and the ALU, and owns both the ALU's input side and its result side.

## Interface
- DATA_W, 8, operand and result width
- OP_W, 4, ALU operation width
- SYNC, 4'hA, required upper nibble of the opcode byte
- ALU_LAT, 1, cycles between the ALU inputs becoming stable and the result being sampled; legal range 0..7
- TIMEOUT, 16, idle cycles allowed between bytes within a frame before the frame is aborted; 0 disables the timeout

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  DATA_W  command byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  sequencer can accept a byte
- alu_data_in1  out  DATA_W  operand A to the ALU
- alu_data_in2  out  DATA_W  operand B to the ALU
- alu_operation  out  OP_W  operation to the ALU
- alu_data_out  in  DATA_W  ALU result
- res_data  out  DATA_W  captured result
- res_op  out  OP_W  operation that produced res_data
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts the result
- err  out  1  one-cycle pulse on a bad sync nibble or a frame timeout

## Operation
- States: GET_OP, GET_A, GET_B, EXEC, HOLD. Reset state is GET_OP.
- A byte is accepted on a rising edge with in_valid && in_ready.
- in_ready = 1 in GET_OP, GET_A and GET_B; 0 in EXEC and HOLD.
- GET_OP behaviour on an accepted byte:
  - in_data[7:4] == SYNC: latch in_data[3:0] into the op shadow register and go to GET_A.
  - Otherwise: consume the byte, pulse err, stay in GET_OP.
- GET_A: accepted byte goes to the A shadow register; go to GET_B.
- GET_B: on the accepting edge, load alu_data_in1 = A shadow, alu_data_in2 = in_data, alu_operation = op shadow; go to EXEC.
- EXEC:
  - Lasts ALU_LAT+1 cycles, counted by a 3-bit counter.
  - alu_* outputs stay stable throughout EXEC and HOLD.
  - On the edge ending the last EXEC cycle: res_data ← alu_data_out, res_op ← alu_operation; go to HOLD.
- HOLD: res_valid = 1. On res_valid && res_ready, go to GET_OP. res_data and res_op stay stable while res_ready = 0.
- alu_* outputs keep their last values after HOLD until the next GET_B accept.
- Timeout, applying only in GET_A and GET_B:
  - An idle counter increments each cycle without an accept and clears on every accept.
  - When the count reaches TIMEOUT-1 with no accept that cycle, the next edge aborts the frame: go to GET_OP and pulse err.
  - An accept in the same cycle wins; the frame is not aborted.
- Reset mid-operation, any state: rst_n low immediately forces GET_OP, clears all registers, and discards the partial frame and any pending result.

## Timing
- Reset values:
  - in_ready = 1 (GET_OP).
  - alu_data_in1, alu_data_in2, alu_operation = 0.
  - res_data, res_op = 0.
  - res_valid = 0, err = 0.
- err is registered and is high for exactly one cycle per event.
- Latency: GET_B accept edge to res_valid high = ALU_LAT+1 cycles.
- ALU inputs change only at a GET_B accept edge; never during EXEC or HOLD.
- Throughput with continuous in_valid and res_ready tied high: one frame per ALU_LAT+5 cycles (3 accept + ALU_LAT+1 exec + 1 hold).
- No overlap: a new frame is not accepted while a result is pending.

## Test plan
- Basic frame with defaults, in_valid held high: send 0xA2, 0xCF, 0xB0 → alu_data_in1 = 0xCF, alu_data_in2 = 0xB0, alu_operation = 2 from the edge after the 0xB0 accept; res_valid rises 2 cycles after that edge; res_data equals the ALU model output for op 2 and res_op = 2.
- Bad sync: send 0x52 in GET_OP → err pulses for 1 cycle, state stays GET_OP, in_ready stays 1; a following 0xA3, 0x01, 0x02 completes normally with res_op = 3.
- Backpressure: complete a frame while res_ready = 0 for 10 cycles → res_valid, res_data and the alu_* outputs stay stable and in_ready = 0; raise res_ready → handshake completes and in_ready = 1 the next cycle.
- Timeout with TIMEOUT = 16: send 0xA1, 0x11, then idle → err pulses and the state returns to GET_OP 16 cycles after the 0x11 accept; a byte arriving on cycle 16 exactly is accepted instead and no err occurs.
- Reset mid-frame: assert rst_n low during EXEC → all outputs return to their reset values immediately; after release, no res_valid appears until a new full frame arrives.
- Random sweep: 10 frames with random operations 0..15 and ALU_LAT in {0, 3} → every res_data matches the ALU model, and cycles per frame = ALU_LAT+5.
